// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package   : fpu_pkg                                                |
// | Purpose   : Shared FP32 field layout, rounding modes and helpers    |
// |             used by the FPU execute-path blocks.                   |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
package fpu_pkg;

  // IEEE-754 single precision field layout
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // Per-transaction rounding mode
  typedef enum logic [1:0] {
    RM_RNA = 2'd0,  // nearest, ties away from zero
    RM_RTZ = 2'd1,  // toward zero
    RM_RDN = 2'd2,  // toward -inf
    RM_RUP = 2'd3   // toward +inf
  } rm_e;

  // Operand class resolved at decode time, carried to the rounding stage
  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,  // finite, needs rounding and range check
    KIND_ZERO = 2'd1,  // zero or subnormal, result is 0
    KIND_SAT  = 2'd2   // Inf/NaN/out-of-range, saturate by sign
  } kind_e;

  localparam int FP32_BIAS = 127;

  function automatic logic fp32_is_nan(input fp32_t x);
    return (x.exp == 8'hFF) && (x.man != 23'd0);
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_ftoi_round.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : fpu_ftoi_round                                         |
// | Purpose   : Applies the rounding increment to a truncated magnitude |
// |             using guard/sticky bits, sign and rounding mode.       |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module fpu_ftoi_round
  import fpu_pkg::*;
#(
  parameter int MAG_W = 33
) (
  input  logic [MAG_W-1:0] i_mag,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic             i_sign,
  input  rm_e              i_rm,
  output logic [MAG_W-1:0] o_mag
);

  logic w_inexact;
  logic w_inc;

  // Pick the +1 decision for the magnitude; direction modes depend on sign
  always_comb begin
    w_inexact = i_guard | i_sticky;
    w_inc     = 1'b0;
    case (i_rm)
      RM_RNA:  w_inc = i_guard;
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & w_inexact;
      RM_RUP:  w_inc = ~i_sign & w_inexact;
      default: w_inc = 1'b0;
    endcase
    o_mag = i_mag + MAG_W'(w_inc);
  end

endmodule : fpu_ftoi_round
`default_nettype wire

// File: rtl/fpu_ftoi_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : fpu_ftoi_pipe                                          |
// | Purpose   : Pipelined FP32 -> signed integer converter with        |
// |             per-op rounding mode, saturation and valid/ready flow. |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module fpu_ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int OUT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [1:0]       in_rm,
  input  logic [4:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_ovf,
  output logic [4:0]       out_tag
);

  // One spare magnitude bit absorbs the carry of a rounding increment
  localparam int c_MAG_W    = OUT_W + 1;
  localparam int c_DEC_W    = c_MAG_W + 12;
  localparam int c_FIN_W    = OUT_W + 6;
  localparam int c_INT_EXP  = FP32_BIAS + 23;     // exponent where ulp == 1
  localparam int c_FRAC_EXP = FP32_BIAS - 1;      // below this only sticky survives
  localparam int c_HUGE_EXP = FP32_BIAS + OUT_W;  // magnitude >= 2^OUT_W from here on

  localparam logic [c_MAG_W-1:0] c_MAX_MAG = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [c_MAG_W-1:0] c_MIN_MAG = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]   c_Y_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   c_Y_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  logic [STAGES-1:0]  r_valid;
  logic [c_FIN_W-1:0] r_fin;
  logic               w_adv;

  fp32_t              w_x;
  kind_e              w_kind;
  logic               w_sign, w_guard, w_sticky;
  logic [23:0]        w_sig;
  logic [47:0]        w_ext;
  logic [7:0]         w_lsh, w_rsh;
  logic [c_MAG_W-1:0] w_mag;
  logic [c_DEC_W-1:0] w_dec_in, w_dec_rnd;
  logic               w_src_valid;

  logic [1:0]         w_r_kind, w_r_rm;
  logic               w_r_sign, w_r_guard, w_r_sticky;
  logic [c_MAG_W-1:0] w_r_mag, w_rnd_mag;
  logic [4:0]         w_r_tag;
  logic [OUT_W-1:0]   w_y, w_neg_y;
  logic               w_ovf;
  logic [c_FIN_W-1:0] w_fin;

  // The whole pipe moves together; only a held, unconsumed result stalls it
  assign w_adv     = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[STAGES-1];
  assign {out_ovf, out_y, out_tag} = r_fin;
  assign w_x       = fp32_t'(in_x);
  assign w_sig     = {1'b1, w_x.man};

  // Decode the operand and align it to the integer point with guard/sticky
  always_comb begin
    w_kind   = KIND_NUM;
    w_sign   = w_x.sign;
    w_mag    = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_ext    = '0;
    w_lsh    = '0;
    w_rsh    = '0;
    if (w_x.exp == 8'd0) begin
      w_kind = KIND_ZERO;
    end else if (fp32_is_nan(w_x)) begin
      w_kind = KIND_SAT;
      w_sign = 1'b0;  // NaN always saturates positive
    end else if (w_x.exp >= 8'(c_HUGE_EXP)) begin
      w_kind = KIND_SAT;  // includes +/-Inf
    end else if (w_x.exp >= 8'(c_INT_EXP)) begin
      w_lsh = w_x.exp - 8'(c_INT_EXP);
      w_mag = c_MAG_W'(w_sig) << w_lsh;
    end else if (w_x.exp >= 8'(c_FRAC_EXP)) begin
      w_rsh    = 8'(c_INT_EXP) - w_x.exp;
      w_ext    = {w_sig, 24'd0} >> w_rsh;
      w_mag    = c_MAG_W'(w_ext[47:24]);
      w_guard  = w_ext[23];
      w_sticky = |w_ext[22:0];
    end else begin
      w_sticky = 1'b1;  // |x| < 0.5 and nonzero
    end
  end

  assign w_dec_in = {w_kind, w_sign, in_rm, w_guard, w_sticky, w_mag, in_tag};

  generate
    if (STAGES == 1) begin : g_single
      assign w_dec_rnd   = w_dec_in;
      assign w_src_valid = in_valid;
    end else begin : g_multi
      logic [c_DEC_W-1:0] r_dec [STAGES-1];

      // Decode result in stage 0, then pass-through stages up to the last
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_dec[0] <= w_dec_in;
          for (int s = 1; s < STAGES - 1; s++) begin
            r_dec[s] <= r_dec[s-1];
          end
        end
      end

      assign w_dec_rnd   = r_dec[STAGES-2];
      assign w_src_valid = r_valid[STAGES-2];
    end
  endgenerate

  assign {w_r_kind, w_r_sign, w_r_rm, w_r_guard, w_r_sticky, w_r_mag, w_r_tag} = w_dec_rnd;

  fpu_ftoi_round #(
    .MAG_W (c_MAG_W)
  ) u_round (
    .i_mag    (w_r_mag),
    .i_guard  (w_r_guard),
    .i_sticky (w_r_sticky),
    .i_sign   (w_r_sign),
    .i_rm     (rm_e'(w_r_rm)),
    .o_mag    (w_rnd_mag)
  );

  assign w_neg_y = -w_rnd_mag[OUT_W-1:0];

  // Range check after rounding and apply the sign, saturating out-of-range values
  always_comb begin
    w_y   = '0;
    w_ovf = 1'b0;
    case (w_r_kind)
      KIND_SAT: begin
        w_ovf = 1'b1;
        w_y   = w_r_sign ? c_Y_MIN : c_Y_MAX;
      end
      KIND_NUM: begin
        if (!w_r_sign) begin
          if (w_rnd_mag > c_MAX_MAG) begin
            w_ovf = 1'b1;
            w_y   = c_Y_MAX;
          end else begin
            w_y = w_rnd_mag[OUT_W-1:0];
          end
        end else if (w_rnd_mag > c_MIN_MAG) begin
          w_ovf = 1'b1;
          w_y   = c_Y_MIN;
        end else begin
          w_y = w_neg_y;  // -2^(OUT_W-1) is exact here
        end
      end
      default: begin
        w_y   = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  assign w_fin = {w_ovf, w_y, w_r_tag};

  // Per-stage valid bits shift forward whenever the pipe advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  // Output register; holds its value while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin <= '0;
    end else if (w_adv && w_src_valid) begin
      r_fin <= w_fin;
    end
  end

endmodule : fpu_ftoi_pipe
`default_nettype wire

// File: tb/tb_fpu_ftoi_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : tb_fpu_ftoi_pipe                                       |
// | Purpose   : Self-checking bench for fpu_ftoi_pipe: directed and    |
// |             random conversions, back-pressure and mid-run reset.   |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module tb_fpu_ftoi_pipe;

  localparam int S32 = 2;  // main instance: OUT_W=32
  localparam int S1  = 1;  // OUT_W=32, single stage
  localparam int S16 = 4;  // OUT_W=16, deep pipe

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [31:0] in_x = '0;
  logic [1:0]  in_rm = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready32 = 1'b1, out_ready_b = 1'b1;

  logic        in_ready32, in_ready1, in_ready16;
  logic        out_valid32, out_valid1, out_valid16;
  logic [31:0] out_y32, out_y1;
  logic [15:0] out_y16;
  logic        out_ovf32, out_ovf1, out_ovf16;
  logic [4:0]  out_tag32, out_tag1, out_tag16;

  int checks = 0;
  int errors = 0;

  logic [63:0] last_y32, last_y16;
  logic        last_ovf32, last_ovf16;

  always #5 clk = ~clk;

  fpu_ftoi_pipe #(.STAGES(S32), .OUT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready32),
    .in_x(in_x), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_y(out_y32), .out_ovf(out_ovf32), .out_tag(out_tag32));

  fpu_ftoi_pipe #(.STAGES(S1), .OUT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready1),
    .in_x(in_x), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready_b),
    .out_y(out_y1), .out_ovf(out_ovf1), .out_tag(out_tag1));

  fpu_ftoi_pipe #(.STAGES(S16), .OUT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready16),
    .in_x(in_x), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid16), .out_ready(out_ready_b),
    .out_y(out_y16), .out_ovf(out_ovf16), .out_tag(out_tag16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact rational reference: value = sig * 2^(e-150), rounded by remainder
  // comparison against one half, then clamped to the w-bit signed range.
  function automatic void ref_ftoi(input logic [31:0] x, input logic [1:0] rm, input int w,
                                   output logic [63:0] y, output logic ovf);
    logic signed [199:0] v, q, r, half, maxv, minv;
    int   e, rs;
    logic s, up;
    s    = x[31];
    e    = int'(x[30:23]);
    maxv = (200'sd1 <<< (w - 1)) - 200'sd1;
    minv = -(200'sd1 <<< (w - 1));
    ovf  = 1'b0;
    if (e == 0) begin
      v = '0;
    end else if (e == 255) begin
      ovf = 1'b1;
      v   = (x[22:0] != 23'd0 || !s) ? maxv : minv;
    end else begin
      v = 200'({1'b1, x[22:0]});
      if (e >= 150) begin
        v = v <<< (e - 150);
      end else begin
        rs   = 150 - e;
        q    = v >>> rs;
        r    = v - (q <<< rs);
        half = 200'sd1 <<< (rs - 1);
        case (rm)
          2'd0:    up = (r >= half);
          2'd1:    up = 1'b0;
          2'd2:    up = s && (r != 0);
          default: up = !s && (r != 0);
        endcase
        v = q + 200'(up);
      end
      if (s) v = -v;
      if (v > maxv) begin
        v = maxv; ovf = 1'b1;
      end else if (v < minv) begin
        v = minv; ovf = 1'b1;
      end
    end
    y = v[63:0];
  endfunction

  function automatic logic [31:0] rand_x();
    int         sel;
    logic [7:0] e;
    sel = $urandom_range(0, 11);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(110, 170));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // One transaction into all three instances; checks latency and value of each
  task automatic do_vec(input logic [31:0] x, input logic [1:0] rm, input logic [4:0] tag);
    logic [63:0] e32, e16, y32, y1, y16;
    logic        v32, v16, o32, o1, o16;
    logic [4:0]  t32, t1, t16;
    int          l32 = -1, l1 = -1, l16 = -1;
    y32 = '0; y1 = '0; y16 = '0; o32 = 0; o1 = 0; o16 = 0; t32 = 0; t1 = 0; t16 = 0;
    ref_ftoi(x, rm, 32, e32, v32);
    ref_ftoi(x, rm, 16, e16, v16);
    @(negedge clk);
    in_valid_a = 1'b1; in_valid_b = 1'b1; in_x = x; in_rm = rm; in_tag = tag;
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge clk);
      if (l32 < 0 && out_valid32) begin l32 = n; y32 = {32'd0, out_y32}; o32 = out_ovf32; t32 = out_tag32; end
      if (l1  < 0 && out_valid1)  begin l1  = n; y1  = {32'd0, out_y1};  o1  = out_ovf1;  t1  = out_tag1;  end
      if (l16 < 0 && out_valid16) begin l16 = n; y16 = {48'd0, out_y16}; o16 = out_ovf16; t16 = out_tag16; end
      if (l32 >= 0 && l1 >= 0 && l16 >= 0) break;
    end
    check("lat32", 64'(l32), 64'(S32));
    check("y32",   y32, e32 & 64'hFFFF_FFFF);
    check("ovf32", 64'(o32), 64'(v32));
    check("tag32", 64'(t32), 64'(tag));
    check("lat1",  64'(l1), 64'(S1));
    check("y1",    y1, e32 & 64'hFFFF_FFFF);
    check("ovf1",  64'(o1), 64'(v32));
    check("tag1",  64'(t1), 64'(tag));
    check("lat16", 64'(l16), 64'(S16));
    check("y16",   y16, e16 & 64'hFFFF);
    check("ovf16", 64'(o16), 64'(v16));
    check("tag16", 64'(t16), 64'(tag));
    last_y32 = y32; last_ovf32 = o32; last_y16 = y16; last_ovf16 = o16;
  endtask

  // Directed vectors with OUT_W=32 expectations written out by hand
  logic [31:0] d_x   [15] = '{32'h40200000, 32'h40200000, 32'h40200000, 32'h40200000,
                              32'hC0200000, 32'hC0200000, 32'hC0200000, 32'hC0200000,
                              32'h3E99999A, 32'hBE99999A, 32'h00000001, 32'h4F000000,
                              32'hCF000000, 32'h7F800000, 32'h7FC00000};
  logic [1:0]  d_rm  [15] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                              2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [31:0] d_y   [15] = '{32'd3, 32'd2, 32'd2, 32'd3,
                              32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE,
                              32'd1, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF,
                              32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
  logic        d_ovf [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};

  // OUT_W=16 boundary vectors (32767.5 under RNA rounds into overflow)
  logic [31:0] h_x   [3] = '{32'h47000000, 32'hC7000000, 32'h46FFFF00};
  logic [15:0] h_y   [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
  logic        h_ovf [3] = '{1, 0, 1};

  initial begin
    logic [38:0] exp_q[$];
    logic [38:0] expv, held;
    logic [63:0] ry;
    logic        rov, hold;
    int          sent, got;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_valid16", 64'(out_valid16), 64'd0);
    check("rst_out_y32",     64'(out_y32), 64'd0);
    check("rst_out_ovf32",   64'(out_ovf32), 64'd0);
    check("rst_out_tag32",   64'(out_tag32), 64'd0);
    check("rst_in_ready32",  64'(in_ready32), 64'd1);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      do_vec(d_x[i], d_rm[i], 5'(i));
      check("dir_y32",   last_y32, 64'(d_y[i]));
      check("dir_ovf32", 64'(last_ovf32), 64'(d_ovf[i]));
    end
    for (int i = 0; i < 3; i++) begin
      do_vec(h_x[i], 2'd0, 5'(i + 20));
      check("dir_y16",   last_y16, 64'(h_y[i]));
      check("dir_ovf16", 64'(last_ovf16), 64'(h_ovf[i]));
    end

    // Random conversions against the reference model
    for (int i = 0; i < 40; i++) begin
      do_vec(rand_x(), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end

    // Back-pressure stream of 20 tagged ops on the main instance
    sent = 0; got = 0; hold = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", 64'(out_valid32), 64'd1);
        check("hold_data",  64'({1'b1, out_ovf32, out_y32, out_tag32}), 64'(held));
      end
      out_ready32 = ($urandom_range(0, 2) != 0);
      if (sent < 20 && $urandom_range(0, 4) != 0) begin
        in_valid_a = 1'b1; in_x = rand_x(); in_rm = 2'($urandom_range(0, 3)); in_tag = 5'(sent);
      end else begin
        in_valid_a = 1'b0;
      end
      #1;
      if (out_ready32) check("no_throughput_loss", 64'(in_ready32), 64'd1);
      if (in_valid_a && in_ready32) begin
        ref_ftoi(in_x, in_rm, 32, ry, rov);
        exp_q.push_back({1'b1, rov, ry[31:0], in_tag});
        sent++;
      end
      if (out_valid32 && out_ready32) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 39'd0;
        check("bp_out", 64'({1'b1, out_ovf32, out_y32, out_tag32}), 64'(expv));
        got++;
      end
      hold = out_valid32 && !out_ready32;
      held = {1'b1, out_ovf32, out_y32, out_tag32};
    end
    @(negedge clk);
    in_valid_a = 1'b0; out_ready32 = 1'b1;
    check("bp_sent", 64'(sent), 64'd20);
    check("bp_got",  64'(got), 64'd20);
    check("bp_leftover", 64'(exp_q.size()), 64'd0);

    // Reset with STAGES ops in flight discards them
    for (int k = 0; k < S32; k++) begin
      in_valid_a = 1'b1; in_x = 32'h40200000; in_rm = 2'd0; in_tag = 5'(k + 1);
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid32), 64'd0);
    check("midrst_y",     64'(out_y32), 64'd0);
    check("midrst_ready", 64'(in_ready32), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_out", 64'(out_valid32), 64'd0);
    end
    do_vec(32'h40200000, 2'd1, 5'd7);
    check("post_rst_y32", last_y32, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fpu_ftoi_pipe
`default_nettype wire
